// File: rtl/reg_file_sb.sv
// Parametrised register file with hardwired-zero x0, optional write-to-read
// forwarding and a per-register pending-write scoreboard for hazard detection.
module reg_file_sb #(
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH),
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_RD*AW-1:0] RADR,
    input  logic [NUM_RD-1:0]    RVALID,
    output logic [NUM_RD*DW-1:0] RDATA,
    output logic [NUM_RD-1:0]    RBUSY,
    output logic                 HAZARD,
    input  logic                 WE,
    input  logic [AW-1:0]        WA,
    input  logic [DW-1:0]        WD,
    input  logic                 ISSUE,
    input  logic [AW-1:0]        ISSUE_RD,
    output logic [DEPTH-1:0]     BUSY_VEC
);

    logic [DW-1:0]    mem_r [DEPTH];
    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic             we_s;
    logic             issue_s;

    // Reset masks writes and issues so forwarding cannot leak WD while RST is high.
    assign we_s    = WE && !RST;
    assign issue_s = ISSUE && !RST;

    // Register storage; x0 is cleared by reset and never written afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (we_s && (WA != {AW{1'b0}})) begin
            mem_r[WA] <= WD;
        end
    end

    // Next scoreboard state: an issue to the same register beats the clearing write.
    always_comb begin
        busy_nxt_s = {DEPTH{1'b0}};
        for (int r = 1; r < DEPTH; r++) begin
            if (issue_s && (ISSUE_RD == AW'(r))) begin
                busy_nxt_s[r] = 1'b1;
            end else if (we_s && (WA == AW'(r))) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
    end

    // Scoreboard flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] addr_s;
        logic          zero_s;
        logic          fwd_s;

        assign addr_s = RADR[k*AW +: AW];
        assign zero_s = (addr_s == {AW{1'b0}});
        // A forwarded operand is never reported busy: its producer is writing now.
        assign fwd_s  = (BYPASS != 0) && we_s && (WA == addr_s);

        assign RDATA[k*DW +: DW] = zero_s ? {DW{1'b0}} :
                                   fwd_s  ? WD         : mem_r[addr_s];
        assign RBUSY[k] = !zero_s && !fwd_s && busy_r[addr_s];
    end

    assign HAZARD   = |(RBUSY & RVALID);
    assign BUSY_VEC = busy_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: vector table on the default build, hand sequences for
// no-bypass and mid-run reset, and a random sweep on a 16x16, 4-port build.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // u0: defaults, BYPASS=1
    logic [9:0]  a_radr = '0;
    logic [1:0]  a_rvalid = '0;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic        a_haz;
    logic        a_we = 1'b0;
    logic [4:0]  a_wa = '0;
    logic [31:0] a_wd = '0;
    logic        a_issue = 1'b0;
    logic [4:0]  a_ird = '0;
    logic [31:0] a_bv;

    // u1: defaults, BYPASS=0
    logic [9:0]  b_radr = '0;
    logic [1:0]  b_rvalid = '0;
    logic [63:0] b_rdata;
    logic [1:0]  b_rbusy;
    logic        b_haz;
    logic        b_we = 1'b0;
    logic [4:0]  b_wa = '0;
    logic [31:0] b_wd = '0;
    logic        b_issue = 1'b0;
    logic [4:0]  b_ird = '0;
    logic [31:0] b_bv;

    // u2: DEPTH=16, DW=16, NUM_RD=4
    logic [15:0] c_radr = '0;
    logic [3:0]  c_rvalid = '0;
    logic [63:0] c_rdata;
    logic [3:0]  c_rbusy;
    logic        c_haz;
    logic        c_we = 1'b0;
    logic [3:0]  c_wa = '0;
    logic [15:0] c_wd = '0;
    logic        c_issue = 1'b0;
    logic [3:0]  c_ird = '0;
    logic [15:0] c_bv;

    reg_file_sb #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1)) u0 (
        .CLK(clk), .RST(rst), .RADR(a_radr), .RVALID(a_rvalid), .RDATA(a_rdata),
        .RBUSY(a_rbusy), .HAZARD(a_haz), .WE(a_we), .WA(a_wa), .WD(a_wd),
        .ISSUE(a_issue), .ISSUE_RD(a_ird), .BUSY_VEC(a_bv));

    reg_file_sb #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0)) u1 (
        .CLK(clk), .RST(rst), .RADR(b_radr), .RVALID(b_rvalid), .RDATA(b_rdata),
        .RBUSY(b_rbusy), .HAZARD(b_haz), .WE(b_we), .WA(b_wa), .WD(b_wd),
        .ISSUE(b_issue), .ISSUE_RD(b_ird), .BUSY_VEC(b_bv));

    reg_file_sb #(.DW(16), .DEPTH(16), .NUM_RD(4), .BYPASS(1)) u2 (
        .CLK(clk), .RST(rst), .RADR(c_radr), .RVALID(c_rvalid), .RDATA(c_rdata),
        .RBUSY(c_rbusy), .HAZARD(c_haz), .WE(c_we), .WA(c_wa), .WD(c_wd),
        .ISSUE(c_issue), .ISSUE_RD(c_ird), .BUSY_VEC(c_bv));

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        issue;
        logic [4:0]  ird;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  rv;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eb;
        logic        eh;
        logic [31:0] ebv;
    } vec_t;

    vec_t tbl [15];

    logic [15:0] m_mem  [16];
    logic        m_busy [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] e_rd;
        logic [3:0]  e_rb;
        logic [15:0] e_bv;
        logic [3:0]  a;

        tbl[0]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 32'h0,        32'h0,        2'b00, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd0, 2'b11, 32'hA5A5A5A5, 32'h0,        2'b00, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 5'd3, 32'h11,       1'b0, 5'd0, 5'd3, 5'd0, 2'b01, 32'h11,       32'h0,        2'b00, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 5'd3, 32'h22,       1'b0, 5'd0, 5'd3, 5'd7, 2'b11, 32'h22,       32'hA5A5A5A5, 2'b00, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd3, 5'd9, 2'b10, 32'h22,       32'h0,        2'b00, 1'b0, 32'h200};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd9, 2'b10, 32'h22,       32'h0,        2'b10, 1'b1, 32'h200};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd9, 2'b00, 32'h22,       32'h0,        2'b10, 1'b0, 32'h200};
        tbl[8]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd3, 5'd9, 2'b10, 32'h22,       32'h99,       2'b00, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 2'b11, 32'h99,       32'h99,       2'b00, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd0, 2'b01, 32'h0,        32'h0,        2'b00, 1'b0, 32'h10};
        tbl[11] = '{1'b1, 5'd4, 32'h55,       1'b1, 5'd4, 5'd4, 5'd0, 2'b01, 32'h55,       32'h0,        2'b00, 1'b0, 32'h10};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd0, 2'b01, 32'h55,       32'h0,        2'b01, 1'b1, 32'h10};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 32'h0,        32'h0,        2'b00, 1'b0, 32'h10};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd4, 2'b11, 32'h0,        32'h55,       2'b10, 1'b1, 32'h10};

        // Reset state
        tick();
        tick();
        chk("reset_rdata_u0", a_rdata, 64'h0);
        chk("reset_bv_u0", {32'h0, a_bv}, 64'h0);
        chk("reset_rdata_u2", c_rdata, 64'h0);
        #2 rst = 1'b0;

        // Vector table on u0
        for (int i = 0; i < 15; i++) begin
            tick();
            a_we = tbl[i].we;   a_wa = tbl[i].wa;   a_wd = tbl[i].wd;
            a_issue = tbl[i].issue; a_ird = tbl[i].ird;
            a_radr = {tbl[i].ra1, tbl[i].ra0}; a_rvalid = tbl[i].rv;
            #2;
            chk($sformatf("tbl%0d_rdata", i), a_rdata, {tbl[i].ed1, tbl[i].ed0});
            chk($sformatf("tbl%0d_rbusy_haz", i), {61'h0, a_rbusy, a_haz}, {61'h0, tbl[i].eb, tbl[i].eh});
            tick();
            chk($sformatf("tbl%0d_busy_vec", i), {32'h0, a_bv}, {32'h0, tbl[i].ebv});
        end
        a_we = 1'b0; a_issue = 1'b0; a_rvalid = 2'b00;

        // No-bypass build: write cycle returns the stored value
        b_we = 1'b1; b_wa = 5'd3; b_wd = 32'h11;
        tick();
        b_wd = 32'h22; b_radr = {5'd0, 5'd3};
        #2 chk("nobyp_pre_edge", b_rdata, {32'h0, 32'h11});
        tick();
        b_we = 1'b0;
        #1 chk("nobyp_post_edge", b_rdata, {32'h0, 32'h22});
        b_issue = 1'b1; b_ird = 5'd9;
        tick();
        b_issue = 1'b0;
        b_we = 1'b1; b_wa = 5'd9; b_wd = 32'h5; b_radr = {5'd9, 5'd3}; b_rvalid = 2'b10;
        #2 chk("nobyp_busy_in_write", {61'h0, b_rbusy, b_haz}, {61'h0, 2'b10, 1'b1});
        chk("nobyp_data_in_write", b_rdata, {32'h0, 32'h22});
        tick();
        b_we = 1'b0;
        chk("nobyp_bv_cleared", {32'h0, b_bv}, 64'h0);
        #1 chk("nobyp_after_write", {b_rdata[63:32], 29'h0, b_rbusy, b_haz}, {32'h5, 32'h0});

        // Mid-operation reset on u0
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF;
        tick();
        a_we = 1'b0; a_radr = {5'd7, 5'd5};
        #1 chk("pre_rst_reg5", a_rdata, {32'hA5A5A5A5, 32'hDEADBEEF});
        #1 rst = 1'b1;
        #1 chk("async_rst_rdata", a_rdata, 64'h0);
        chk("async_rst_bv", {32'h0, a_bv}, 64'h0);
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'h77; a_issue = 1'b1; a_ird = 5'd6;
        a_radr = {5'd5, 5'd5}; a_rvalid = 2'b11;
        #1 chk("rst_no_bypass", {a_rdata[63:0]}, 64'h0);
        chk("rst_no_hazard", {61'h0, a_rbusy, a_haz}, 64'h0);
        tick();
        rst = 1'b0;
        a_we = 1'b0; a_issue = 1'b0;
        #1 chk("post_rst_reg5", a_rdata, 64'h0);
        tick();
        chk("post_rst_bv", {32'h0, a_bv}, 64'h0);

        // Random sweep on the 16x16x4 build
        for (int r = 0; r < 16; r++) begin
            m_mem[r]  = 16'h0;
            m_busy[r] = 1'b0;
        end
        for (int n = 0; n < 10000; n++) begin
            tick();
            c_we    = ($urandom_range(0, 1) == 1);
            c_wa    = 4'($urandom_range(0, 15));
            c_wd    = 16'($urandom);
            c_issue = ($urandom_range(0, 2) == 0);
            c_ird   = ($urandom_range(0, 3) == 0) ? c_wa : 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                c_radr[k*4 +: 4] = ($urandom_range(0, 3) == 0) ? c_wa : 4'($urandom_range(0, 15));
            end
            c_rvalid = 4'($urandom_range(0, 15));
            #2;
            e_bv = '0;
            for (int r = 0; r < 16; r++) e_bv[r] = m_busy[r];
            for (int k = 0; k < 4; k++) begin
                a = c_radr[k*4 +: 4];
                if (a == 4'd0) begin
                    e_rd[k*16 +: 16] = 16'h0;
                    e_rb[k] = 1'b0;
                end else if (c_we && c_wa == a) begin
                    e_rd[k*16 +: 16] = c_wd;
                    e_rb[k] = 1'b0;
                end else begin
                    e_rd[k*16 +: 16] = m_mem[a];
                    e_rb[k] = m_busy[a];
                end
            end
            chk("rand_rdata", c_rdata, e_rd);
            chk("rand_rbusy_haz", {59'h0, c_rbusy, c_haz}, {59'h0, e_rb, |(e_rb & c_rvalid)});
            chk("rand_busy_vec", {48'h0, c_bv}, {48'h0, e_bv});
            if (c_we && c_wa != 4'd0) m_mem[c_wa] = c_wd;
            if (c_we) m_busy[c_wa] = 1'b0;
            if (c_issue && c_ird != 4'd0) m_busy[c_ird] = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor of the OTTER register file, intended for the pipelined OTTER core.
- Provides N asynchronous read ports, one synchronous write port, an optional write-to-read bypass, a hardwired zero register and an asynchronous clear.
- Adds a per-register pending-write scoreboard. Decode marks a destination busy at issue, and writeback clears it. Decode uses the per-port busy flags and the HAZARD output to stall on read-after-write hazards.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, >=2.
- AW, $clog2(DEPTH), address width (derived; do not override).
- NUM_RD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value only.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- RADR  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- RVALID  in  NUM_RD  port k's operand is actually used this cycle (gates HAZARD).
- RDATA  out  NUM_RD*DW  read data; port k occupies bits [k*DW +: DW].
- RBUSY  out  NUM_RD  port k's address has an outstanding pending write.
- HAZARD  out  1  OR over k of (RBUSY[k] & RVALID[k]).
- WE  in  1  write enable.
- WA  in  AW  write address.
- WD  in  DW  write data.
- ISSUE  in  1  mark ISSUE_RD as pending.
- ISSUE_RD  in  AW  destination being issued.
- BUSY_VEC  out  DEPTH  raw scoreboard bits, for debug and the hazard unit.

Behaviour:
- Storage: DEPTH x DW flops.
  - On RST assertion, all registers clear to 0 and all busy bits clear to 0 immediately, without waiting for a clock edge.
  - While RST is high, writes and issues are ignored and all outputs are driven as if every register were 0 and not busy.
- Register 0:
  - Reads always return 0.
  - Never written; WE with WA=0 is a no-op.
  - Never busy; ISSUE with ISSUE_RD=0 is a no-op.
- Write: at a rising CLK edge with WE=1 and WA!=0, reg[WA] <= WD.
- Read (combinational, zero-latency):
  - RDATA[k] = 0 if RADR[k]=0.
  - Otherwise, if BYPASS=1 and WE=1 and WA==RADR[k], RDATA[k] = WD.
  - Otherwise RDATA[k] = reg[RADR[k]].
  - All ports are independent; any number of ports may read the same address.
- Scoreboard update at a rising CLK edge, per register r:
  - Set if ISSUE=1 and ISSUE_RD=r.
  - Otherwise cleared if WE=1 and WA=r.
  - Otherwise held.
  - When issue and write target the same r in the same cycle, set wins: the new producer is still outstanding.
- Busy outputs:
  - RBUSY[k] = busy[RADR[k]], with one exception: when BYPASS=1, WE=1 and WA==RADR[k], RBUSY[k]=0, because the value is being forwarded.
  - RBUSY[k]=0 whenever RADR[k]=0.
  - RBUSY and HAZARD are purely combinational from current state and inputs; no cycle delay.
- Re-issue: ISSUE to an already-busy register keeps it busy. There is no counting; a single write clears it. The pipeline guarantees in-order writeback.
- WE to a non-busy register is legal and writes normally; busy stays 0.
- Reset mid-operation: pending writes are lost, busy bits clear, and the first post-reset read of any register returns 0.

Test Plan:
- Reset clear: write reg5=0xDEADBEEF, pulse RST between edges -> RDATA for reg5 = 0 immediately, BUSY_VEC = 0, without a clock edge.
- Write/read and x0: WE, WA=0, WD=0x1234; then WE, WA=7, WD=0xA5A5A5A5 -> reading reg0 returns 0; reading reg7 on all NUM_RD ports returns 0xA5A5A5A5 after the edge.
- Bypass: BYPASS=1, reg3=0x11, same cycle WE, WA=3, WD=0x22 with RADR0=3 -> RDATA0=0x22 before the edge. With BYPASS=0 the same stimulus -> RDATA0=0x11 before the edge and 0x22 after.
- Scoreboard: ISSUE, ISSUE_RD=9 -> BUSY_VEC[9]=1 next cycle. RADR1=9, RVALID1=1 -> RBUSY1=1, HAZARD=1. RVALID1=0 -> HAZARD=0. WE, WA=9 -> with BYPASS=1, RBUSY1=0 in the write cycle; with either setting, BUSY_VEC[9]=0 after the edge.
- Simultaneous events: busy[4]=1, same cycle ISSUE, ISSUE_RD=4 and WE, WA=4, WD=0x55 -> reg4=0x55 and BUSY_VEC[4]=1 after the edge. ISSUE, ISSUE_RD=0 -> BUSY_VEC[0] stays 0.
- Parameter sweep: DEPTH=16, DW=16, NUM_RD=4 -> random writes and reads against a reference model for 10k cycles; all ports match, and no access to an address >= DEPTH is generated.
